sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Parametrised N-channel sram-like arbiter that merges several CPU-side sram-like master channels onto one sram-like slave port toward the AXI bridge. It replaces the fixed split inst/data ports with a single shared port and supports multiple outstanding transactions. An in-order ID FIFO routes each returned `data_ok`/`rdata` to the issuing channel. It sits between the pipeline's fetch/mem request logic and the sram-like-to-AXI converter.

## Interface
- NUM_CH, 2: number of master channels; channel 0 is fetch, channel 1 is data, up to 8.
- MAX_OUTSTANDING, 4: depth of the in-order ID FIFO, i.e. max accepted-but-unreturned requests; power of 2, ≥2.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- m_req  in  NUM_CH  per-channel request.
- m_wr  in  NUM_CH  per-channel write flag.
- m_size  in  2*NUM_CH  per-channel size; channel i in [2i+1:2i].
- m_addr  in  ADDR_W*NUM_CH  per-channel address.
- m_wdata  in  DATA_W*NUM_CH  per-channel write data.
- m_addr_ok  out  NUM_CH  one-hot address accept.
- m_data_ok  out  NUM_CH  one-hot data return.
- m_rdata  out  DATA_W  read data, shared and broadcast to all channels.
- s_req, s_wr  out  1  slave request and write flag.
- s_size  out  2  slave size.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_rdata  in  DATA_W  slave read data.
- s_addr_ok, s_data_ok  in  1  slave handshakes.
- err_sticky  out  1  set when `s_data_ok` arrives with the FIFO empty.

## Operation
- Grant selection:
  - Unlocked: grant the highest-priority channel with `m_req`=1, per the arbitration policy in Configuration.
  - Locked: the grant register wins regardless of `m_req`.
- Lock: when `s_req`=1 and `s_addr_ok`=0, latch `lock`=1 and the granted ID. Clear `lock` on the cycle `s_addr_ok`=1. The sram-like rule forbids switching a request before `addr_ok`.
- Slave request path: `s_req` = granted `m_req` & ~fifo_full & ~reset. `s_wr`, `s_size`, `s_addr` and `s_wdata` are muxed from the granted channel and are combinational.
- Address accept: `m_addr_ok[g]` = `s_req` & `s_addr_ok`. All other bits are 0.
- Push: on `s_req` & `s_addr_ok`, push the granted ID (clog2(NUM_CH) bits) at the FIFO tail.
- Pop: on `s_data_ok` with the FIFO non-empty, pop the head, assert `m_data_ok[head]`=1 for that cycle, and drive `m_rdata`=`s_rdata`. Writes also pop.
- Occupancy counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on push only, −1 on pop only.
  - Unchanged when push and pop occur in the same cycle.
  - Read/write pointers wrap modulo MAX_OUTSTANDING.
- Full: count==MAX_OUTSTANDING forces `s_req`=0, even if a pop occurs in the same cycle. Full takes priority, for timing.
- Empty: `s_data_ok` with count==0 is ignored. No `m_data_ok` is raised, the counter does not underflow, and `err_sticky`←1.
- Reset mid-transaction:
  - Outstanding IDs are discarded and the lock is cleared.
  - Late `s_data_ok` after reset sets `err_sticky`.
  - The slave must be reset together with this block.

## Timing
- Reset values:
  - `s_req`=0 and all `m_addr_ok`=0, `m_data_ok`=0 during reset.
  - `err_sticky`=0, count=0, pointers=0, `lock`=0, round-robin pointer=0.
  - Data outputs follow the muxes; they are don't-care while `s_req`=0.
- Request path `m_req`→`s_req`: 0-cycle, combinational.
- `s_addr_ok`→`m_addr_ok`: 0-cycle.
- `s_data_ok`→`m_data_ok`: 0-cycle.
- Push/pop take effect on the next edge. A request accepted in cycle t may return as early as cycle t+1.
- Back-to-back accepts are allowed every cycle until full.
- Returns are strictly in acceptance order. The slave must preserve order.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - The pointer advances to (granted ID + 1) mod NUM_CH on each accept.
  - Search starts at the pointer.
- Undefined: fixed priority, lowest index wins; channel 0 (fetch) always beats channel 1. There is no pointer register.

## Test plan
- Single read, NUM_CH=2: ch1 reads 0x1000 and the slave returns 0xDEADBEEF two cycles later → `m_addr_ok`=2'b10 at accept, `m_data_ok`=2'b10, `m_rdata`=0xDEADBEEF.
- Contention: ch0 and ch1 both request every cycle, slave addr_ok always 1.
  - Fixed priority: ch0 wins 4/4 accepts.
  - With `SRAM_ARB_RR_EN`: grants alternate 0,1,0,1.
- Lock: ch1 requests, `s_addr_ok` held 0 for 3 cycles, ch0 raises `m_req` in cycle 2 → `s_addr` stays ch1's address until accept; ch0 is granted the next cycle.
- Full: MAX_OUTSTANDING=4, 4 accepts with no returns → 5th request sees `s_req`=0. One `s_data_ok` → `s_req` reasserts the following cycle; returns go out in issue order with IDs 0,1,0,1.
- Simultaneous push/pop at count=2 → count stays 2, pointers both advance; wrap from 3→0 is verified.
- Spurious `s_data_ok` with the FIFO empty → no `m_data_ok`, `err_sticky`=1 until `reset`, count stays 0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - N-channel sram-like arbiter with in-order ID FIFO for returns
// Optional SRAM_ARB_RR_EN selects round-robin arbitration; default is fixed priority (lowest index wins).
module sram_like_arbiter #(
  parameter int NUM_CH          = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        m_req,
  input  logic [NUM_CH-1:0]        m_wr,
  input  logic [2*NUM_CH-1:0]      m_size,
  input  logic [ADDR_W*NUM_CH-1:0] m_addr,
  input  logic [DATA_W*NUM_CH-1:0] m_wdata,
  output logic [NUM_CH-1:0]        m_addr_ok,
  output logic [NUM_CH-1:0]        m_data_ok,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     s_req,
  output logic                     s_wr,
  output logic [1:0]               s_size,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic [DATA_W-1:0]        s_rdata,
  input  logic                     s_addr_ok,
  input  logic                     s_data_ok,
  output logic                     err_sticky
);

  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

  logic [IDW-1:0] pick;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] lock_id;
  logic           lock;
  logic [IDW-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

`ifdef SRAM_ARB_RR_EN
  logic [IDW-1:0] rr_ptr;
  logic           found;

  // Search starts at the pointer and wraps; with no requester the grant idles on the pointer.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && m_req[(int'(rr_ptr) + k) % NUM_CH]) begin
        pick  = IDW'((int'(rr_ptr) + k) % NUM_CH);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
    end
  end
`else
  always_comb begin
    pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (m_req[k]) pick = IDW'(k);
    end
  end
`endif

  // A request presented but not yet accepted must not be switched away from.
  assign grant = lock ? lock_id : pick;
  assign full  = (count == CW'(MAX_OUTSTANDING));
  assign empty = (count == '0);

  assign s_req   = m_req[grant] & ~full & ~reset;
  assign s_wr    = m_wr[grant];
  assign s_size  = m_size[int'(grant)*2 +: 2];
  assign s_addr  = m_addr[int'(grant)*ADDR_W +: ADDR_W];
  assign s_wdata = m_wdata[int'(grant)*DATA_W +: DATA_W];

  assign push    = s_req & s_addr_ok;
  assign pop     = s_data_ok & ~empty & ~reset;
  assign m_rdata = s_rdata;

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_addr_ok[i] = push & (grant == IDW'(i));
      m_data_ok[i] = pop & (fifo_mem[rd_ptr] == IDW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lock       <= 1'b0;
      lock_id    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (s_data_ok && empty) err_sticky <= 1'b1;
      if (s_req && !s_addr_ok) begin
        lock    <= 1'b1;
        lock_id <= grant;
      end else if (s_addr_ok) begin
        lock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - self-checking bench for sram_like_arbiter
// Directed scenarios with literal expectations, then randomized traffic against a queue-based model.
module tb_sram_like_arbiter;

  localparam int NUM_CH = 2;
  localparam int MAXO   = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_CH-1:0]    m_req, m_wr;
  logic [2*NUM_CH-1:0]  m_size;
  logic [AW*NUM_CH-1:0] m_addr;
  logic [DW*NUM_CH-1:0] m_wdata;
  logic [NUM_CH-1:0]    m_addr_ok, m_data_ok;
  logic [DW-1:0]        m_rdata;
  logic                 s_req, s_wr;
  logic [1:0]           s_size;
  logic [AW-1:0]        s_addr;
  logic [DW-1:0]        s_wdata;
  logic [DW-1:0]        s_rdata;
  logic                 s_addr_ok, s_data_ok;
  logic                 err_sticky;

  always #5 clk = ~clk;

  sram_like_arbiter #(.NUM_CH(NUM_CH), .MAX_OUTSTANDING(MAXO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
    .err_sticky(err_sticky)
  );

  int tests = 0;
  int fails = 0;
  bit run_cmp = 1'b0;

  // Model: outstanding channel IDs in issue order, pending (locked) channel, rr pointer, error flag.
  int                q[$];
  int                locked_ch = -1;
  int                rr = 0;
  bit                err_m = 1'b0;
  logic [NUM_CH-1:0] acc_mask = '0;

  function automatic int exp_grant();
    if (locked_ch >= 0) return locked_ch;
`ifdef SRAM_ARB_RR_EN
    for (int k = 0; k < NUM_CH; k++) if (m_req[(rr + k) % NUM_CH]) return (rr + k) % NUM_CH;
    return rr;
`else
    for (int k = 0; k < NUM_CH; k++) if (m_req[k]) return k;
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int g;
    bit sreq;
    bit acc;
    acc_mask = '0;
    if (reset) begin
      q.delete();
      locked_ch = -1;
      rr        = 0;
      err_m     = 1'b0;
    end else begin
      g    = exp_grant();
      sreq = m_req[g] && (q.size() < MAXO);
      acc  = sreq && s_addr_ok;
      if (s_data_ok) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1'b1;
      end
      if (acc) begin
        q.push_back(g);
        rr = (g + 1) % NUM_CH;
        acc_mask[g] = 1'b1;
      end
      if (sreq && !s_addr_ok) locked_ch = g;
      else if (s_addr_ok) locked_ch = -1;
    end
  end

  always @(negedge clk) begin
    int g;
    bit esreq;
    logic [NUM_CH-1:0] eao;
    logic [NUM_CH-1:0] edo;
    if (run_cmp) begin
      g     = exp_grant();
      esreq = !reset && m_req[g] && (q.size() < MAXO);
      check("s_req", s_req, esreq);
      if (esreq) begin
        check("s_addr", s_addr, m_addr[g*AW +: AW]);
        check("s_wr", s_wr, m_wr[g]);
        check("s_size", s_size, m_size[g*2 +: 2]);
        check("s_wdata", s_wdata, m_wdata[g*DW +: DW]);
      end
      eao = '0;
      if (esreq && s_addr_ok) eao[g] = 1'b1;
      check("m_addr_ok", m_addr_ok, eao);
      edo = '0;
      if (!reset && s_data_ok && q.size() > 0) edo[q[0]] = 1'b1;
      check("m_data_ok", m_data_ok, edo);
      if (edo != '0) check("m_rdata", m_rdata, s_rdata);
      check("err_sticky", err_sticky, err_m);
    end
  end

  task automatic set_ch(input int c, input bit req, input bit wr, input logic [1:0] sz,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req[c]          = req;
    m_wr[c]           = wr;
    m_size[c*2 +: 2]  = sz;
    m_addr[c*AW +: AW] = a;
    m_wdata[c*DW +: DW] = d;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  logic [NUM_CH-1:0] grants [4];
  logic [NUM_CH-1:0] exp_g  [4];
  bit                pending [NUM_CH];

  initial begin
    reset = 1'b1; m_req = '1; m_wr = '0; m_size = '0; m_addr = '0; m_wdata = '0;
    s_rdata = '0; s_addr_ok = 1'b1; s_data_ok = 1'b1;
    next();
    run_cmp = 1'b1;
    @(negedge clk);
    check("reset_s_req", s_req, 0);
    check("reset_m_addr_ok", m_addr_ok, 0);
    check("reset_m_data_ok", m_data_ok, 0);
    next();
    reset = 1'b0; m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    @(negedge clk);
    check("reset_err_sticky", err_sticky, 0);
    next();

    // Single read on channel 1 returning two cycles after accept.
    set_ch(1, 1, 0, 2'd2, 32'h1000, 32'h0);
    s_addr_ok = 1'b1;
    @(negedge clk);
    check("rd_addr_ok", m_addr_ok, 2'b10);
    check("rd_s_addr", s_addr, 32'h1000);
    next();
    m_req = '0; s_addr_ok = 1'b0;
    next();
    s_data_ok = 1'b1; s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("rd_data_ok", m_data_ok, 2'b10);
    check("rd_rdata", m_rdata, 32'hDEADBEEF);
    next();
    s_data_ok = 1'b0;

    // Contention: both channels request every cycle with addr_ok always high.
    set_ch(0, 1, 0, 2'd2, 32'h100, 32'h0);
    set_ch(1, 1, 1, 2'd2, 32'h200, 32'h55);
    s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data_ok = (i > 0);
      @(negedge clk);
      grants[i] = m_addr_ok;
      next();
    end
    m_req = '0; s_data_ok = 1'b1;
    next();
    s_data_ok = 1'b0; s_addr_ok = 1'b0;
`ifdef SRAM_ARB_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    for (int i = 0; i < 4; i++) check($sformatf("contention_grant%0d", i), grants[i], exp_g[i]);

    // Lock: channel 1 stalls three cycles, channel 0 arrives meanwhile.
    set_ch(1, 1, 0, 2'd2, 32'h2000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_ch(0, 1, 0, 2'd2, 32'h3000, 32'h0);
      @(negedge clk);
      check("lock_s_addr", s_addr, 32'h2000);
      check("lock_no_accept", m_addr_ok, 2'b00);
      next();
    end
    s_addr_ok = 1'b1;
    @(negedge clk);
    check("lock_accept_ch1", m_addr_ok, 2'b10);
    next();
    m_req[1] = 1'b0;
    @(negedge clk);
    check("lock_then_ch0", m_addr_ok, 2'b01);
    check("lock_then_ch0_addr", s_addr, 32'h3000);
    next();
    m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    next();
    next();
    s_data_ok = 1'b0;

    // Full: four alternating accepts, then stall, then push/pop with wrap.
    s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_req = '0;
      set_ch(i % 2, 1, 0, 2'd2, 32'h4000 + 32'(i * 4), 32'h0);
      @(negedge clk);
      check("full_fill_accept", m_addr_ok, (i % 2) ? 2'b10 : 2'b01);
      next();
    end
    m_req = '0;
    set_ch(0, 1, 0, 2'd2, 32'h5000, 32'h0);
    @(negedge clk);
    check("full_s_req_low", s_req, 0);
    check("full_no_accept", m_addr_ok, 0);
    next();
    s_data_ok = 1'b1;
    @(negedge clk);
    check("full_pop_s_req_low", s_req, 0);
    check("full_ret0", m_data_ok, 2'b01);
    next();
    @(negedge clk);
    check("full_reassert", s_req, 1);
    check("full_reaccept", m_addr_ok, 2'b01);
    check("full_ret1", m_data_ok, 2'b10);
    next();
    m_req = '0;
    @(negedge clk);
    check("full_ret2", m_data_ok, 2'b01);
    next();
    set_ch(1, 1, 0, 2'd2, 32'h6000, 32'h0);
    @(negedge clk);
    check("pushpop_accept", m_addr_ok, 2'b10);
    check("pushpop_ret3", m_data_ok, 2'b10);
    next();
    m_req = '0;
    @(negedge clk);
    check("wrap_ret4", m_data_ok, 2'b01);
    next();
    @(negedge clk);
    check("wrap_ret5", m_data_ok, 2'b10);
    next();

    // Spurious return with the FIFO empty.
    @(negedge clk);
    check("spurious_no_data_ok", m_data_ok, 0);
    next();
    s_data_ok = 1'b0;
    @(negedge clk);
    check("spurious_err", err_sticky, 1);
    next();
    reset = 1'b1;
    next();
    reset = 1'b0;
    @(negedge clk);
    check("err_cleared", err_sticky, 0);
    next();

    // Randomized traffic: masters hold requests until accepted (occasionally dropping).
    for (int c = 0; c < NUM_CH; c++) pending[c] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (acc_mask[c] || reset) pending[c] = 1'b0;
        if (!pending[c] && ($urandom % 2 == 0)) begin
          pending[c] = 1'b1;
          set_ch(c, 1, 1'($urandom), 2'($urandom), $urandom, $urandom);
        end
        m_req[c] = pending[c] && ($urandom % 16 != 0);
      end
      s_addr_ok = ($urandom % 10) < 7;
      s_data_ok = ($urandom % 10) < 4;
      s_rdata   = $urandom;
      reset     = ($urandom % 300) == 0;
      next();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
